// File: rtl/dest_reg_tracker.sv
// Tracks destination registers of in-flight instructions through a DEPTH-stage
// shift pipeline and flags source operands that match a pending write.
module dest_reg_tracker #(
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 3,
  parameter int LINK_REG = 31,
  localparam int SW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] rt,
  input  logic [ADDR_W-1:0] rd,
  input  logic [1:0]        rd_select,
  input  logic              reg_write,
  input  logic              issue_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] src_a,
  input  logic [ADDR_W-1:0] src_b,
  output logic [ADDR_W-1:0] sel_dest,
  output logic [ADDR_W-1:0] wb_dest,
  output logic              wb_valid,
  output logic              hazard_a,
  output logic              hazard_b,
  output logic [SW-1:0]     hazard_a_stage,
  output logic [SW-1:0]     hazard_b_stage,
  output logic [CW-1:0]     inflight_count
);

  logic [DEPTH-1:0]  stage_valid;
  logic [ADDR_W-1:0] stage_dest [DEPTH];
  logic              new_valid;

  always_comb begin
    case (rd_select)
      2'd1:    sel_dest = rd;
      2'd2:    sel_dest = ADDR_W'(LINK_REG);
      default: sel_dest = rt;
    endcase
  end

  // Register 0 is hardwired, so writes to it never create a dependency.
  assign new_valid = issue_valid & reg_write & (sel_dest != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_valid <= '0;
      for (int i = 0; i < DEPTH; i++) stage_dest[i] <= '0;
    end else if (flush) begin
      stage_valid <= '0;
    end else if (!stall) begin
      stage_valid[0] <= new_valid;
      stage_dest[0]  <= sel_dest;
      for (int i = 1; i < DEPTH; i++) begin
        stage_valid[i] <= stage_valid[i-1];
        stage_dest[i]  <= stage_dest[i-1];
      end
    end
  end

  assign wb_valid = stage_valid[DEPTH-1];
  assign wb_dest  = stage_dest[DEPTH-1];

  // Scan oldest to youngest so the youngest matching stage wins.
  always_comb begin
    hazard_a       = 1'b0;
    hazard_b       = 1'b0;
    hazard_a_stage = '0;
    hazard_b_stage = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (stage_valid[i] && (src_a != '0) && (stage_dest[i] == src_a)) begin
        hazard_a       = 1'b1;
        hazard_a_stage = SW'(i);
      end
      if (stage_valid[i] && (src_b != '0) && (stage_dest[i] == src_b)) begin
        hazard_b       = 1'b1;
        hazard_b_stage = SW'(i);
      end
    end
  end

  always_comb begin
    inflight_count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      inflight_count = inflight_count + CW'(stage_valid[i]);
    end
  end

endmodule

// File: tb/tb_dest_reg_tracker.sv
// Directed bench for dest_reg_tracker: three instances (DEPTH 3, 1, 8) share
// one set of inputs; expected values are hand-computed per step.
module tb_dest_reg_tracker;

  logic       clk;
  logic       reset_n;
  logic [4:0] rt, rd, src_a, src_b;
  logic [1:0] rd_select;
  logic       reg_write, issue_valid, stall, flush;

  logic [4:0] sel3, wbd3, sel1, wbd1, sel8, wbd8;
  logic       wbv3, hza3, hzb3, wbv1, hza1, hzb1, wbv8, hza8, hzb8;
  logic [1:0] hzsa3, hzsb3, cnt3;
  logic [0:0] hzsa1, hzsb1, cnt1;
  logic [2:0] hzsa8, hzsb8;
  logic [3:0] cnt8;

  int checks = 0;
  int errors = 0;

  dest_reg_tracker #(.DEPTH(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .rt(rt), .rd(rd), .rd_select(rd_select),
    .reg_write(reg_write), .issue_valid(issue_valid), .stall(stall), .flush(flush),
    .src_a(src_a), .src_b(src_b), .sel_dest(sel3), .wb_dest(wbd3), .wb_valid(wbv3),
    .hazard_a(hza3), .hazard_b(hzb3), .hazard_a_stage(hzsa3), .hazard_b_stage(hzsb3),
    .inflight_count(cnt3));

  dest_reg_tracker #(.DEPTH(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .rt(rt), .rd(rd), .rd_select(rd_select),
    .reg_write(reg_write), .issue_valid(issue_valid), .stall(stall), .flush(flush),
    .src_a(src_a), .src_b(src_b), .sel_dest(sel1), .wb_dest(wbd1), .wb_valid(wbv1),
    .hazard_a(hza1), .hazard_b(hzb1), .hazard_a_stage(hzsa1), .hazard_b_stage(hzsb1),
    .inflight_count(cnt1));

  dest_reg_tracker #(.DEPTH(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .rt(rt), .rd(rd), .rd_select(rd_select),
    .reg_write(reg_write), .issue_valid(issue_valid), .stall(stall), .flush(flush),
    .src_a(src_a), .src_b(src_b), .sel_dest(sel8), .wb_dest(wbd8), .wb_valid(wbv8),
    .hazard_a(hza8), .hazard_b(hzb8), .hazard_a_stage(hzsa8), .hazard_b_stage(hzsb8),
    .inflight_count(cnt8));

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] sel, input logic [4:0] rt_v, input logic [4:0] rd_v);
    issue_valid = 1'b1;
    reg_write   = 1'b1;
    rd_select   = sel;
    rt          = rt_v;
    rd          = rd_v;
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    reg_write   = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; rt = '0; rd = 5'd9; rd_select = 2'd1; reg_write = 1'b0;
    issue_valid = 1'b0; stall = 1'b0; flush = 1'b0; src_a = '0; src_b = '0;

    // Reset state; sel_dest still follows its inputs
    #2;
    check("rst_cnt3", cnt3, 0);
    check("rst_wbv3", wbv3, 0);
    check("rst_wbd3", wbd3, 0);
    check("rst_hza3", hza3, 0);
    check("rst_sel3", sel3, 9);
    @(negedge clk);
    reset_n = 1'b1;

    // Single issue of rd=7, watched through all three depths
    issue(2'd1, 5'd3, 5'd7);
    src_a = 5'd7;
    #1;
    check("a_sel3", sel3, 7);
    check("a_hz_issue_excl", hza3, 0);
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 1) idle();
      #1;
      check("a_cnt3", cnt3, (k <= 3) ? 1 : 0);
      check("a_wbv3", wbv3, (k == 3) ? 1 : 0);
      check("a_hza3", hza3, (k <= 3) ? 1 : 0);
      check("a_hzsa3", hzsa3, (k <= 3) ? k - 1 : 0);
      check("a_wbv1", wbv1, (k == 1) ? 1 : 0);
      check("a_cnt1", cnt1, (k == 1) ? 1 : 0);
      check("a_wbv8", wbv8, (k == 8) ? 1 : 0);
      check("a_cnt8", cnt8, (k <= 8) ? 1 : 0);
      check("a_hzsa8", hzsa8, (k <= 8) ? k - 1 : 0);
      if (k == 1) check("a_wbd1", wbd1, 7);
      if (k == 3) check("a_wbd3", wbd3, 7);
      if (k == 8) check("a_wbd8", wbd8, 7);
    end

    // Link register destination, then a zero destination that is not tracked
    src_a = '0;
    issue(2'd2, 5'd0, 5'd0);
    #1;
    check("b_sel_link", sel3, 31);
    tick();
    idle();
    src_a = 5'd31;
    #1;
    check("b_hza", hza3, 1);
    check("b_hzsa", hzsa3, 0);
    check("b_cnt", cnt3, 1);
    issue(2'd0, 5'd0, 5'd4);
    #1;
    check("b_sel_rt0", sel3, 0);
    tick();
    idle();
    rd_select = 2'd3; rt = 5'd12;
    #1;
    check("b_cnt_unchanged", cnt3, 1);
    check("b_hzsa_shift", hzsa3, 1);
    check("b_sel_sel3", sel3, 12);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    src_a = '0;
    #1;
    check("b_flush_cnt", cnt3, 0);

    // Two writes to r5, youngest match wins; stall holds everything
    issue(2'd1, 5'd0, 5'd5);
    tick();
    idle();
    tick();
    issue(2'd1, 5'd0, 5'd5);
    tick();
    idle();
    src_b = 5'd5;
    #1;
    check("c_hzb", hzb3, 1);
    check("c_hzsb", hzsb3, 0);
    check("c_cnt", cnt3, 2);
    check("c_wbv", wbv3, 1);
    check("c_wbd", wbd3, 5);
    stall = 1'b1;
    issue(2'd1, 5'd0, 5'd9);
    src_a = 5'd9;
    tick();
    tick();
    #1;
    check("c_stall_cnt", cnt3, 2);
    check("c_stall_hzsb", hzsb3, 0);
    check("c_stall_wbv", wbv3, 1);
    check("c_stall_wbd", wbd3, 5);
    check("c_stall_drop", hza3, 0);
    stall = 1'b0;
    idle();
    tick();
    #1;
    check("c_after_cnt", cnt3, 1);
    check("c_after_hzsb", hzsb3, 1);
    check("c_after_wbv", wbv3, 0);

    // Fill all stages, then flush beats stall and issue
    src_a = '0; src_b = '0;
    issue(2'd1, 5'd0, 5'd1);
    tick();
    rd = 5'd2;
    tick();
    rd = 5'd3;
    tick();
    idle();
    src_a = 5'd2;
    #1;
    check("d_full_cnt", cnt3, 3);
    check("d_full_wbd", wbd3, 1);
    check("d_full_hzsa", hzsa3, 1);
    flush = 1'b1; stall = 1'b1;
    issue(2'd1, 5'd0, 5'd4);
    src_b = 5'd4;
    tick();
    flush = 1'b0; stall = 1'b0;
    idle();
    #1;
    check("d_flush_cnt", cnt3, 0);
    check("d_flush_wbv", wbv3, 0);
    check("d_flush_hza", hza3, 0);
    check("d_flush_hzb", hzb3, 0);

    // Asynchronous reset pulse between edges
    src_a = '0; src_b = '0;
    issue(2'd1, 5'd0, 5'd10);
    tick();
    rd = 5'd11;
    tick();
    idle();
    src_a = 5'd10;
    #1;
    check("e_pre_cnt", cnt3, 2);
    check("e_pre_hzsa", hzsa3, 1);
    reset_n = 1'b0;
    #1;
    check("e_rst_cnt", cnt3, 0);
    check("e_rst_hza", hza3, 0);
    check("e_rst_hzsa", hzsa3, 0);
    reset_n = 1'b1;
    issue(2'd1, 5'd0, 5'd13);
    src_a = 5'd13;
    tick();
    idle();
    #1;
    check("e_post_cnt", cnt3, 1);
    check("e_post_hza", hza3, 1);
    check("e_post_hzsa", hzsa3, 0);
    tick();
    tick();
    #1;
    check("e_post_wbv", wbv3, 1);
    check("e_post_wbd", wbd3, 13);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dest_reg_tracker.md
DEST_REG_TRACKER -- requirements
Module: dest_reg_tracker

Interface
REQ-001 Parameter ADDR_W, default 5, register-address width.
REQ-002 Parameter DEPTH, default 3, number of in-flight tracking stages; legal range 1..8.
REQ-003 Parameter LINK_REG, default 31, link-register index for JAL/BLTZAL/BGEZAL.
REQ-004 Derived widths: SW = max(1, clog2(DEPTH)); CW = clog2(DEPTH+1).
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 rt  input  ADDR_W  instruction[20:16].
REQ-008 rd  input  ADDR_W  instruction[15:11].
REQ-009 rd_select  input  2  destination select from control: 0 = rt, 1 = rd, 2 = LINK_REG, 3 = rt.
REQ-010 reg_write  input  1  issuing instruction writes a register.
REQ-011 issue_valid  input  1  an instruction is issuing this cycle.
REQ-012 stall  input  1  freeze all tracking stages.
REQ-013 flush  input  1  invalidate all in-flight entries.
REQ-014 src_a, src_b  input  ADDR_W each  source registers of the issuing instruction.
REQ-015 sel_dest  output  ADDR_W  combinational selected destination.
REQ-016 wb_dest, wb_valid  output  ADDR_W, 1  oldest stage (DEPTH-1) contents.
REQ-017 hazard_a, hazard_b  output  1 each  source matches an in-flight destination.
REQ-018 hazard_a_stage, hazard_b_stage  output  SW each  youngest matching stage index.
REQ-019 inflight_count  output  CW  number of valid stages.

Function
REQ-020 sel_dest SHALL follow the select mapping of REQ-009 combinationally, with no clock dependency.
REQ-021 New entry valid = issue_valid & reg_write & (sel_dest != 0); writes to register 0 SHALL never be tracked.
REQ-022 Stages 0..DEPTH-1 each hold {valid, dest}; stage 0 is the youngest.
REQ-023 Rising edge with flush=1: all valid bits SHALL clear, overriding stall and issue; dest fields are don't-care.
REQ-024 Rising edge with flush=0, stall=1: all stages SHALL hold; the issuing entry is dropped (the issuing stage is also stalled upstream).
REQ-025 Rising edge with flush=0, stall=0: stage0 <= new entry and stage[i] <= stage[i-1]; the stage DEPTH-1 entry retires.
REQ-026 wb_dest and wb_valid SHALL be driven directly from stage DEPTH-1 registers (no extra latency); an entry reaches wb after DEPTH unstalled edges.
REQ-027 hazard_x SHALL be 1 when src_x != 0 and any valid stage has dest == src_x; the issuing entry itself SHALL be excluded.
REQ-028 hazard_x_stage SHALL be the lowest matching stage index, and 0 when hazard_x=0.
REQ-029 inflight_count SHALL be the popcount of the stage valid bits, ranging 0..DEPTH.
REQ-030 For DEPTH=1, stage 0 is also the wb stage and the stage outputs are constant 0.
REQ-031 Hazard and count outputs SHALL be combinational from registered state only, plus src_a/src_b.

Reset
REQ-032 reset_n low SHALL immediately clear all valid bits and dest fields to 0, independent of clk.
REQ-033 During reset: wb_valid=0, wb_dest=0, hazard_*=0, hazard_*_stage=0, inflight_count=0; sel_dest still tracks its inputs.
REQ-034 Reset asserted mid-operation SHALL discard all in-flight entries; the first edge after release behaves as REQ-023..025 with empty stages.

Verification
REQ-035 DEPTH=3: issue rd_select=1, rd=7, reg_write=1 -> sel_dest=7 same cycle; wb_valid=1, wb_dest=7 after exactly 3 unstalled edges; inflight_count goes 1, 1, 1, then 0.
REQ-036 rd_select=2 with reg_write=1, then src_a=31 next cycle -> hazard_a=1, hazard_a_stage=0; rd_select=0 with rt=0 -> no entry, inflight_count unchanged.
REQ-037 Issue dest 5 twice, two cycles apart, then src_b=5 -> hazard_b=1, hazard_b_stage=0 (youngest); hold stall=1 for 2 edges -> all outputs unchanged.
REQ-038 Fill 3 stages, then assert flush together with stall and issue_valid -> next edge inflight_count=0, wb_valid=0, no hazards.
REQ-039 Fill 2 stages, pulse reset_n low between edges -> outputs clear before the next clk edge; after release, a new issue propagates normally.
REQ-040 Repeat REQ-035 with DEPTH=1 and DEPTH=8 -> wb latency 1 and 8 respectively; hazard_*_stage width 1 and 3.
